// File: rtl/maxpool_relu_2.sv
// -----------------------------------------------------------------------------
// maxpool_relu_2
//
// 2x2 max-pooling followed by ReLU on three lockstep channels of signed
// conv2 results. Input frames are (2*HALF_HEIGHT) x (2*HALF_WIDTH) samples
// per channel in raster order; each 2x2 window produces one unsigned pooled
// value per channel, qualified by a one-cycle valid_out_relu pulse.
//
// Parameters
//   CONV_BIT    : width of each sample (signed in, unsigned out)
//   HALF_WIDTH  : pooled columns per row (input row = 2*HALF_WIDTH samples)
//   HALF_HEIGHT : pooled rows per frame (input frame = 2*HALF_HEIGHT rows)
//
// Ports
//   clk                    : clock, all state updates on the rising edge
//   rst_n                  : asynchronous active-low reset
//   valid_in               : one sample per channel accepted when high
//   conv_out_1..3          : signed input samples, channels 1..3
//   max_value_1..3         : pooled, ReLU'd result per channel (registered,
//                            held between pulses)
//   valid_out_relu         : one-cycle pulse qualifying max_value_1..3
//   frame_done             : (only with MAXPOOL2_FRAME_DONE_EN) pulses with
//                            the last valid_out_relu pulse of each frame
//
// Configuration
//   `define MAXPOOL2_FRAME_DONE_EN adds the frame_done output.
//
// Window flow, indexed by (row parity, column parity):
//   (even, even) : temp    <= sample
//   (even, odd ) : buf[c/2] <= max(temp, sample)       -- top half of window
//   (odd,  even) : temp    <= max(sample, buf[c/2])
//   (odd,  odd ) : out     <= relu(max(temp, sample))  -- window complete
// -----------------------------------------------------------------------------
module maxpool_relu_2 #(
    parameter int CONV_BIT    = 12,
    parameter int HALF_WIDTH  = 4,
    parameter int HALF_HEIGHT = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       valid_in,
    input  logic signed [CONV_BIT-1:0] conv_out_1,
    input  logic signed [CONV_BIT-1:0] conv_out_2,
    input  logic signed [CONV_BIT-1:0] conv_out_3,
    output logic        [CONV_BIT-1:0] max_value_1,
    output logic        [CONV_BIT-1:0] max_value_2,
    output logic        [CONV_BIT-1:0] max_value_3,
    output logic                       valid_out_relu
`ifdef MAXPOOL2_FRAME_DONE_EN
    ,
    output logic                       frame_done
`endif
);

    localparam int NUM_CH = 3;
    localparam int COL_W  = $clog2(2 * HALF_WIDTH);
    localparam int ROW_W  = $clog2(2 * HALF_HEIGHT);
    localparam int BUF_W  = COL_W - 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(2 * HALF_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(2 * HALF_HEIGHT - 1);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [BUF_W-1:0] buf_idx;

    logic signed [CONV_BIT-1:0] sample   [NUM_CH];
    logic signed [CONV_BIT-1:0] temp     [NUM_CH];
    logic signed [CONV_BIT-1:0] line_buf [NUM_CH][HALF_WIDTH];
    logic signed [CONV_BIT-1:0] pair_max [NUM_CH];
    logic signed [CONV_BIT-1:0] col_max  [NUM_CH];
    logic        [CONV_BIT-1:0] relu_val [NUM_CH];
    logic        [CONV_BIT-1:0] max_val  [NUM_CH];

    function automatic logic signed [CONV_BIT-1:0] smax(
        input logic signed [CONV_BIT-1:0] a,
        input logic signed [CONV_BIT-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    // Each pair of input columns shares one line-buffer entry.
    assign buf_idx = col[COL_W-1:1];

    // NOTE: every signal driven from always_comb gets a value on every path,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        sample[0] = conv_out_1;
        sample[1] = conv_out_2;
        sample[2] = conv_out_3;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            pair_max[ch] = smax(temp[ch], sample[ch]);
            col_max[ch]  = smax(sample[ch], line_buf[ch][buf_idx]);
            relu_val[ch] = pair_max[ch][CONV_BIT-1] ? '0 : pair_max[ch];
        end
    end

    // NOTE: the line buffer sits in the reset branch on purpose: a frame cut
    // short by reset must not leak partial window maxima into the next frame,
    // so this memory is built from resettable flops rather than RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col            <= '0;
            row            <= '0;
            valid_out_relu <= 1'b0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                temp[ch]    <= '0;
                max_val[ch] <= '0;
                for (int i = 0; i < HALF_WIDTH; i++) begin
                    line_buf[ch][i] <= '0;
                end
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values, independent of statement order.
            valid_out_relu <= valid_in && row[0] && col[0];
            if (valid_in) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    case ({row[0], col[0]})
                        2'b00:   temp[ch]              <= sample[ch];
                        2'b01:   line_buf[ch][buf_idx] <= pair_max[ch];
                        2'b10:   temp[ch]              <= col_max[ch];
                        default: max_val[ch]           <= relu_val[ch];
                    endcase
                end
            end
        end
    end

`ifdef MAXPOOL2_FRAME_DONE_EN
    // The last sample of a frame is always odd-row/odd-column, so this pulse
    // lines up with the final valid_out_relu pulse of the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= valid_in && (row == ROW_LAST) && (col == COL_LAST);
        end
    end
`endif

    assign max_value_1 = max_val[0];
    assign max_value_2 = max_val[1];
    assign max_value_3 = max_val[2];

endmodule

// File: tb/tb_maxpool_relu_2.sv
// -----------------------------------------------------------------------------
// tb_maxpool_relu_2
//
// Self-checking bench for maxpool_relu_2. A reference model stores every
// accepted sample into a full frame image and, when a 2x2 window completes,
// takes the maximum of its four samples and applies ReLU. Outputs are
// compared one time unit after each rising edge: valid_out_relu, all three
// max_value outputs (held values included) and, when built with
// MAXPOOL2_FRAME_DONE_EN, frame_done.
// -----------------------------------------------------------------------------
module tb_maxpool_relu_2;

    localparam int CB = 12;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 valid_in = 1'b0;
    logic signed [CB-1:0] conv_out_1 = '0;
    logic signed [CB-1:0] conv_out_2 = '0;
    logic signed [CB-1:0] conv_out_3 = '0;
    logic        [CB-1:0] max_value_1;
    logic        [CB-1:0] max_value_2;
    logic        [CB-1:0] max_value_3;
    logic                 valid_out_relu;
`ifdef MAXPOOL2_FRAME_DONE_EN
    logic                 frame_done;
`endif

    always #5 clk = ~clk;

    maxpool_relu_2 #(
        .CONV_BIT   (CB),
        .HALF_WIDTH (4),
        .HALF_HEIGHT(4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .valid_in      (valid_in),
        .conv_out_1    (conv_out_1),
        .conv_out_2    (conv_out_2),
        .conv_out_3    (conv_out_3),
        .max_value_1   (max_value_1),
        .max_value_2   (max_value_2),
        .max_value_3   (max_value_3),
        .valid_out_relu(valid_out_relu)
`ifdef MAXPOOL2_FRAME_DONE_EN
        ,
        .frame_done    (frame_done)
`endif
    );

    typedef struct {
        string                name;
        logic signed [CB-1:0] w00;
        logic signed [CB-1:0] w01;
        logic signed [CB-1:0] w10;
        logic signed [CB-1:0] w11;
        int                   exp_first;
    } win_vec_t;

    win_vec_t win_tab[4];

    int n_checks = 0;
    int n_errors = 0;

    logic signed [CB-1:0] frame_in [3][8][8];
    logic signed [CB-1:0] m_frame  [3][8][8];
    int m_row, m_col, m_pulses;
    int m_val [3];
    int cap1[$];
    int cap2[$];
    int cap3[$];
    int dut_pulses;
    int fd_count;
    int gap_mode;
    int gap_phase;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int relu_max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m < 0) ? 0 : m;
    endfunction

    function automatic logic signed [CB-1:0] rnd_sample();
        case ($urandom_range(0, 7))
            0:       return CB'(-2048);
            1:       return CB'(2047);
            2:       return '0;
            default: return CB'($urandom);
        endcase
    endfunction

    task automatic model_reset();
        m_row    = 0;
        m_col    = 0;
        m_pulses = 0;
        for (int ch = 0; ch < 3; ch++) m_val[ch] = 0;
    endtask

    // One clock: apply inputs, let the edge happen, update model, compare.
    task automatic drive_cycle(input bit v, input logic signed [CB-1:0] s1,
                               input logic signed [CB-1:0] s2, input logic signed [CB-1:0] s3);
        bit exp_pulse;
        bit exp_fd;
        valid_in   = v;
        conv_out_1 = s1;
        conv_out_2 = s2;
        conv_out_3 = s3;
        @(posedge clk);
        exp_pulse = 1'b0;
        exp_fd    = 1'b0;
        if (v) begin
            m_frame[0][m_row][m_col] = s1;
            m_frame[1][m_row][m_col] = s2;
            m_frame[2][m_row][m_col] = s3;
            if ((m_row % 2 == 1) && (m_col % 2 == 1)) begin
                exp_pulse = 1'b1;
                m_pulses++;
                exp_fd = (m_pulses % 16 == 0);
                for (int ch = 0; ch < 3; ch++) begin
                    m_val[ch] = relu_max4(m_frame[ch][m_row-1][m_col-1], m_frame[ch][m_row-1][m_col],
                                          m_frame[ch][m_row][m_col-1],   m_frame[ch][m_row][m_col]);
                end
            end
            m_col++;
            if (m_col == 8) begin
                m_col = 0;
                m_row = (m_row + 1) % 8;
            end
        end
        #1;
        check("valid_out_relu", 32'(valid_out_relu), 32'(exp_pulse));
        check("max_value_1", 32'(max_value_1), m_val[0]);
        check("max_value_2", 32'(max_value_2), m_val[1]);
        check("max_value_3", 32'(max_value_3), m_val[2]);
`ifdef MAXPOOL2_FRAME_DONE_EN
        check("frame_done", 32'(frame_done), 32'(exp_fd));
        if (frame_done === 1'b1) fd_count++;
`endif
        if (valid_out_relu === 1'b1) begin
            dut_pulses++;
            cap1.push_back(int'(max_value_1));
            cap2.push_back(int'(max_value_2));
            cap3.push_back(int'(max_value_3));
        end
    endtask

    task automatic next_valid(output bit v);
        case (gap_mode)
            1: begin
                v = (gap_phase % 4 == 0) || (gap_phase % 4 == 3);
                gap_phase++;
            end
            2:       v = ($urandom_range(0, 2) != 0);
            default: v = 1'b1;
        endcase
    endtask

    // Feed the first n samples of frame_in in raster order, inserting idle
    // cycles (with junk on the data inputs) according to gap_mode.
    task automatic feed(input int n);
        bit v;
        for (int idx = 0; idx < n; idx++) begin
            for (int g = 0; g < 8; g++) begin
                next_valid(v);
                if (v) break;
                drive_cycle(1'b0, rnd_sample(), rnd_sample(), rnd_sample());
            end
            drive_cycle(1'b1, frame_in[0][idx/8][idx%8], frame_in[1][idx/8][idx%8],
                        frame_in[2][idx/8][idx%8]);
        end
    endtask

    task automatic clear_caps();
        cap1.delete();
        cap2.delete();
        cap3.delete();
        dut_pulses = 0;
    endtask

    task automatic fill_ramp();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                frame_in[0][r][c] = CB'(r * 8 + c);
                frame_in[1][r][c] = rnd_sample();
                frame_in[2][r][c] = rnd_sample();
            end
    endtask

    task automatic fill_const(input int v);
        for (int ch = 0; ch < 3; ch++)
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++) frame_in[ch][r][c] = CB'(v);
    endtask

    task automatic fill_random();
        for (int ch = 0; ch < 3; ch++)
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++) frame_in[ch][r][c] = rnd_sample();
    endtask

    // Ramp frame: pooled channel-1 sequence is (2*pr+1)*8 + (2*pc+1).
    task automatic check_ramp_caps(input string name);
        check({name, " pulse count"}, dut_pulses, 16);
        for (int k = 0; k < cap1.size() && k < 16; k++) begin
            check({name, " ch1 value"}, cap1[k], (2 * (k / 4) + 1) * 8 + 2 * (k % 4) + 1);
        end
    endtask

    task automatic apply_reset(input string name);
        rst_n = 1'b0;
        #2;
        check({name, " reset valid_out_relu"}, 32'(valid_out_relu), 0);
        check({name, " reset max_value_1"}, 32'(max_value_1), 0);
        check({name, " reset max_value_2"}, 32'(max_value_2), 0);
        check({name, " reset max_value_3"}, 32'(max_value_3), 0);
`ifdef MAXPOOL2_FRAME_DONE_EN
        check({name, " reset frame_done"}, 32'(frame_done), 0);
`endif
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        win_tab[0] = '{"window all negative", CB'(-100), CB'(-3), CB'(-7), CB'(-50), 0};
        win_tab[1] = '{"window one positive", CB'(-100), CB'(7),  CB'(-7), CB'(-50), 7};
        win_tab[2] = '{"window extremes",     CB'(5), CB'(-2048), CB'(2047), CB'(0), 2047};
        win_tab[3] = '{"window all minimum",  CB'(-2048), CB'(-2048), CB'(-2048), CB'(-2048), 0};

        gap_mode  = 0;
        gap_phase = 0;
        fd_count  = 0;
        model_reset();
        clear_caps();
        apply_reset("initial");

        // Continuous ramp frame.
        fill_ramp();
        clear_caps();
        feed(64);
        check_ramp_caps("ramp");

        // Constant negative frame: every pooled output clamps to zero.
        fill_const(-5);
        clear_caps();
        feed(64);
        check("const -5 pulse count", dut_pulses, 16);

        // Channel-2 first-window vectors, all other samples -1.
        for (int i = 0; i < 4; i++) begin
            fill_const(-1);
            frame_in[1][0][0] = win_tab[i].w00;
            frame_in[1][0][1] = win_tab[i].w01;
            frame_in[1][1][0] = win_tab[i].w10;
            frame_in[1][1][1] = win_tab[i].w11;
            clear_caps();
            feed(64);
            check(win_tab[i].name, (cap2.size() > 0) ? cap2[0] : -1, win_tab[i].exp_first);
        end

        // Ramp with a 1,0,0,1 valid_in pattern.
        gap_mode  = 1;
        gap_phase = 0;
        fill_ramp();
        clear_caps();
        feed(64);
        check_ramp_caps("gapped ramp");

        // Reset after 20 samples, then a fresh ramp frame.
        gap_mode = 0;
        fill_ramp();
        feed(20);
        apply_reset("mid-frame");
        clear_caps();
        fill_ramp();
        feed(64);
        check_ramp_caps("ramp after reset");

        // Two back-to-back random frames with random gaps.
        gap_mode = 2;
        fd_count = 0;
        clear_caps();
        fill_random();
        feed(64);
        fill_random();
        feed(64);
        check("random frames pulse count", dut_pulses, 32);
`ifdef MAXPOOL2_FRAME_DONE_EN
        check("frame_done count", fd_count, 2);
`endif

        // Trailing idle cycles: outputs must hold with no further pulses.
        gap_mode = 0;
        repeat (4) drive_cycle(1'b0, rnd_sample(), rnd_sample(), rnd_sample());

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/maxpool_relu_2.md
MAXPOOL_RELU_2 -- requirements
Module: maxpool_relu_2

Interface
REQ-001 Parameter CONV_BIT, default 12: width of each signed input sample and unsigned output sample.
REQ-002 Parameter HALF_WIDTH, default 4: pooled columns per row (input row is 2*HALF_WIDTH = 8 samples).
REQ-003 Parameter HALF_HEIGHT, default 4: pooled rows per frame (input frame is 2*HALF_HEIGHT = 8 rows).
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 valid_in  input  1  one sample per channel accepted on each rising edge where high.
REQ-007 conv_out_1, conv_out_2, conv_out_3  input  CONV_BIT each  signed conv2 results, channels 1..3, raster order.
REQ-008 max_value_1, max_value_2, max_value_3  output  CONV_BIT each  pooled, ReLU'd result per channel, registered.
REQ-009 valid_out_relu  output  1  one-cycle pulse qualifying max_value_1..3.

Function
REQ-010 Input frame SHALL be 8x8 per channel in raster order; valid_in gaps of any length SHALL be tolerated with all state held.
REQ-011 Column counter (0..7) and row counter (0..7) SHALL advance only on accepted samples; column wraps 7->0 and increments row; row wraps 7->0 at frame end, next frame begins with no idle cycle.
REQ-012 Even row, even column: sample SHALL be held in a per-channel temp register.
REQ-013 Even row, odd column: signed max(temp, sample) SHALL be written to per-channel line buffer entry col/2 (HALF_WIDTH entries x 3 channels).
REQ-014 Odd row, even column: temp SHALL load signed max(sample, buffer[col/2]).
REQ-015 Odd row, odd column: result = signed max(temp, sample); max_value_n SHALL register 0 if result negative, else result; valid_out_relu SHALL pulse high on the following edge.
REQ-016 Latency SHALL be exactly one clock from the accepting edge of the odd-row/odd-column sample to valid_out_relu high; exactly 16 pulses per frame.
REQ-017 All comparisons SHALL be two's-complement signed; ties select either operand (identical value).
REQ-018 max_value_n SHALL hold its last value while valid_out_relu is low.
REQ-019 Channels SHALL be processed in lockstep by one shared counter pair.

Reset
REQ-020 rst_n low SHALL asynchronously clear counters, temp registers, line buffer, max_value_1..3 to 0 and valid_out_relu to 0.
REQ-021 Reset asserted mid-frame SHALL discard the partial frame; first accepted sample after release is row 0, column 0.
REQ-022 No output pulse SHALL occur in the cycle reset is released.

Configuration
REQ-023 Macro MAXPOOL2_FRAME_DONE_EN defined: module SHALL add output frame_done (1 bit, reset 0) pulsing high coincident with the 16th valid_out_relu pulse of each frame.
REQ-024 Macro MAXPOOL2_FRAME_DONE_EN undefined: frame_done port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-025 Continuous valid_in, channel 1 sample = row*8+col -> max_value_1 sequence 9,11,13,15,25,...,63, one pulse per 2 input cycles on odd rows, 16 pulses total.
REQ-026 All channels constant -5 (0xFFB) for one frame -> 16 pulses, every max_value_n = 0.
REQ-027 Channel 2 window {-100,-3,-7,-50} at rows 0-1 cols 0-1, others -1 -> first max_value_2 = 0; window {-100,7,-7,-50} -> first max_value_2 = 7.
REQ-028 valid_in toggling 1,0,0,1 pattern with ramp of REQ-025 -> identical output values to REQ-025, pulses delayed accordingly.
REQ-029 rst_n asserted after 20 samples, released, fresh ramp frame applied -> outputs exactly match REQ-025, no stale pulses.
REQ-030 Two back-to-back frames with MAXPOOL2_FRAME_DONE_EN defined -> frame_done high exactly twice, on the 16th and 32nd valid_out_relu pulses.
